// File: rtl/serialize_data.sv
// Pixel-word serializer: one LANES*12-bit group per two cycles,
// bit-interleaved low half then high half, idle fill with underrun count.
module serialize_data #(
    parameter int          LANES     = 4,
    parameter logic [11:0] IDLE_WORD = 12'h03F,
    parameter int          CNT_W     = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [LANES*12-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [LANES*6-1:0]   out_data,
    output logic                 clk_out,
    output logic                 out_word_valid,
    input  logic                 clr_underrun,
    output logic [CNT_W-1:0]     underrun_count
);

    localparam int WW = LANES * 12;
    localparam int HW = LANES * 6;
    localparam logic [WW-1:0] IDLE_ALL = {LANES{IDLE_WORD}};

    function automatic logic [HW-1:0] half_of(input logic [WW-1:0] w,
                                              input logic          hi);
        logic [HW-1:0] r;
        r = '0;
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < LANES; k++) begin
                r[LANES*b+k] = w[12*k + (hi ? 6 : 0) + b];
            end
        end
        return r;
    endfunction

    logic [WW-1:0]    hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WW-1:0]    sh_q, sh_d;
    logic             started_q, started_d;
    logic             phase_q, phase_d;
    logic [HW-1:0]    out_q, out_d;
    logic             owv_q, owv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sh_d         = sh_q;
        started_d    = started_q;
        phase_d      = phase_q;
        out_d        = out_q;
        owv_d        = owv_q;
        cnt_d        = cnt_q;

        in_ready = !hold_valid_q || phase_q;
        accept   = in_valid && in_ready;

        if (phase_q) begin
            phase_d = 1'b0;
            if (hold_valid_q) begin
                sh_d         = hold_q;
                out_d        = half_of(hold_q, 1'b0);
                owv_d        = 1'b1;
                hold_valid_d = 1'b0;
            end else begin
                sh_d  = IDLE_ALL;
                out_d = half_of(IDLE_ALL, 1'b0);
                owv_d = 1'b0;
                if (started_q && cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            phase_d = 1'b1;
            out_d   = half_of(sh_q, 1'b1);
        end

        // A same-edge accept refills hold after the load emptied it.
        if (accept) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
            started_d    = 1'b1;
        end

        if (clr_underrun) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sh_q         <= '0;
            started_q    <= 1'b0;
            phase_q      <= 1'b1;
            out_q        <= '0;
            owv_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sh_q         <= sh_d;
            started_q    <= started_d;
            phase_q      <= phase_d;
            out_q        <= out_d;
            owv_q        <= owv_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_data       = out_q;
    assign clk_out        = phase_q;
    assign out_word_valid = owv_q;
    assign underrun_count = cnt_q;

endmodule

// File: tb/tb_serialize_data.sv
// Bench for serialize_data: vector table, transaction-level model with
// random stimulus, underrun saturation and mid-word reset sequences.
module tb_serialize_data;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [47:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] out_data;
    logic        clk_out;
    logic        out_word_valid;
    logic        clr_underrun = 1'b0;
    logic [1:0]  underrun_count;

    serialize_data #(
        .LANES(4),
        .IDLE_WORD(12'h03F),
        .CNT_W(2)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .clk_out(clk_out),
        .out_word_valid(out_word_valid),
        .clr_underrun(clr_underrun),
        .underrun_count(underrun_count)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // model state: queue of accepted words waiting for a word slot
    logic [47:0] pend[$];
    logic [47:0] sent[$];
    logic        m_phase;
    logic        m_owv;
    logic        m_started;
    logic [23:0] m_out;
    logic [47:0] m_cur;
    int          m_cnt;
    bit          last_acc;
    int          cov_hold_load = 0;

    logic [23:0] rx_lo;
    bit          have_lo;
    int          rx_words = 0;

    typedef struct {
        string       name;
        logic [47:0] w;
        logic [23:0] lo;
        logic [23:0] hi;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [23:0] half_of(input logic [47:0] w, input int p);
        logic [23:0] r;
        for (int i = 0; i < 24; i++) r[i] = w[(i % 4) * 12 + 6 * p + i / 4];
        return r;
    endfunction

    function automatic logic [47:0] unhalf(input logic [23:0] lo,
                                           input logic [23:0] hi);
        logic [47:0] w;
        for (int i = 0; i < 24; i++) begin
            w[(i % 4) * 12 + i / 4]     = lo[i];
            w[(i % 4) * 12 + 6 + i / 4] = hi[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        pend.delete();
        sent.delete();
        m_phase   = 1'b1;
        m_owv     = 1'b0;
        m_out     = '0;
        m_cur     = '0;
        m_cnt     = 0;
        m_started = 1'b0;
        have_lo   = 1'b0;
        last_acc  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [47:0] d,
                              input logic clr);
        bit ready, acc;
        ready = (pend.size() == 0) || m_phase;
        acc   = v && ready;
        if (acc && m_phase && pend.size() > 0) cov_hold_load++;
        if (m_phase) begin
            if (pend.size() > 0) begin
                m_cur = pend.pop_front();
                m_owv = 1'b1;
            end else begin
                m_cur = {4{12'h03F}};
                m_owv = 1'b0;
                if (m_started && m_cnt < 3) m_cnt++;
            end
            m_out   = half_of(m_cur, 0);
            m_phase = 1'b0;
        end else begin
            m_out   = half_of(m_cur, 1);
            m_phase = 1'b1;
        end
        if (acc) begin
            pend.push_back(d);
            sent.push_back(d);
            m_started = 1'b1;
        end
        if (clr) m_cnt = 0;
        last_acc = acc;
    endtask

    // called at a negedge; returns at the next negedge
    task automatic cycle(input logic v, input logic [47:0] d, input logic clr);
        in_valid     = v;
        in_data      = d;
        clr_underrun = clr;
        #1;
        check("in_ready", in_ready, (pend.size() == 0) || m_phase);
        @(posedge sys_clk);
        model_edge(v, d, clr);
        @(negedge sys_clk);
        check("outputs", {out_data, clk_out, out_word_valid, underrun_count},
              {m_out, m_phase, m_owv, 2'(m_cnt)});
        if (out_word_valid && !clk_out) begin
            rx_lo   = out_data;
            have_lo = 1'b1;
        end else if (out_word_valid && clk_out && have_lo) begin
            have_lo = 1'b0;
            rx_words++;
            if (sent.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL reassembled actual=%h required=none", unhalf(rx_lo, out_data));
            end else begin
                check("reassembled", unhalf(rx_lo, out_data), sent.pop_front());
            end
        end
    endtask

    function automatic logic [47:0] rand48();
        return {16'($urandom), $urandom};
    endfunction

    initial begin
        logic [47:0] w;
        logic [23:0] lo, hi;
        bit          got_lo, got_hi, reached;
        int          n_acc, gaps, rx0;
        bit          seen_valid;

        vecs[0] = '{"lane0_fff", 48'h000_000_000_FFF, 24'h111111, 24'h111111};
        vecs[1] = '{"lane3_800", 48'h800_000_000_000, 24'h000000, 24'h800000};
        vecs[2] = '{"lane1_001", 48'h000_000_001_000, 24'h000002, 24'h000000};
        vecs[3] = '{"all_03f",   48'h03F_03F_03F_03F, 24'hFFFFFF, 24'h000000};
        vecs[4] = '{"lane2_040", 48'h000_040_000_000, 24'h000000, 24'h000004};

        model_reset();
        repeat (2) begin
            @(negedge sys_clk);
            #1;
            check("reset_vals", {out_data, clk_out, out_word_valid, underrun_count, in_ready},
                  {24'h0, 1'b1, 1'b0, 2'd0, 1'b1});
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        repeat (10) cycle(1'b0, '0, 1'b0);
        check("idle_count", underrun_count, 2'd0);

        foreach (vecs[i]) begin
            for (int t = 0; t < 4; t++) begin
                cycle(1'b1, vecs[i].w, 1'b0);
                if (last_acc) break;
            end
            got_lo = 0;
            got_hi = 0;
            lo = '0;
            hi = '0;
            for (int t = 0; t < 6; t++) begin
                cycle(1'b0, '0, 1'b0);
                if (!got_lo && out_word_valid && !clk_out) begin
                    lo = out_data;
                    got_lo = 1;
                end else if (got_lo && !got_hi && clk_out) begin
                    hi = out_data;
                    got_hi = 1;
                end
            end
            check(vecs[i].name, {got_hi, lo, hi}, {1'b1, vecs[i].lo, vecs[i].hi});
        end

        // underrun saturation with a 2-bit counter
        cycle(1'b0, '0, 1'b1);
        check("clr_count", underrun_count, 2'd0);
        w = rand48();
        for (int t = 0; t < 4; t++) begin
            cycle(1'b1, w, 1'b0);
            if (last_acc) break;
        end
        repeat (14) cycle(1'b0, '0, 1'b0);
        check("underrun_sat", underrun_count, 2'd3);
        if (!m_phase) cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("clr_on_idle_load", {clk_out, underrun_count}, {1'b0, 2'd0});
        repeat (3) cycle(1'b0, '0, 1'b0);

        // back-to-back stream
        n_acc = 0;
        gaps = 0;
        seen_valid = 0;
        rx0 = rx_words;
        w = rand48();
        for (int t = 0; t < 400 && n_acc < 100; t++) begin
            cycle(1'b1, w, t < 2);
            if (seen_valid && !out_word_valid) gaps++;
            if (out_word_valid) seen_valid = 1;
            if (last_acc) begin
                n_acc++;
                w = rand48();
            end
        end
        check("stream_accepts", n_acc, 100);
        check("stream_gaps", gaps, 0);
        check("stream_underrun", underrun_count, 2'd0);
        repeat (4) cycle(1'b0, '0, 1'b0);
        check("stream_rx_words", rx_words - rx0, 100);

        // random valid with backpressure
        w = rand48();
        for (int t = 0; t < 300; t++) begin
            cycle($urandom_range(0, 2) != 0, w, $urandom_range(0, 15) == 0);
            if (last_acc) w = rand48();
        end
        repeat (6) cycle(1'b0, '0, 1'b0);
        check("cover_accept_on_load_with_hold", cov_hold_load > 0, 1'b1);
        check("drained", sent.size(), 0);

        // reset mid-word: high half on the wire, hold occupied
        reached = 0;
        w = rand48();
        for (int t = 0; t < 10; t++) begin
            cycle(1'b1, w, 1'b0);
            if (last_acc) w = rand48();
            if (m_phase && pend.size() == 1) begin
                reached = 1;
                break;
            end
        end
        check("reset_setup_reached", reached, 1'b1);
        in_valid  = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check("async_reset_vals", {out_data, clk_out, out_word_valid, underrun_count, in_ready},
              {24'h0, 1'b1, 1'b0, 2'd0, 1'b1});
        model_reset();
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("held_reset_vals", {out_data, clk_out, out_word_valid, underrun_count},
              {24'h0, 1'b1, 1'b0, 2'd0});
        sys_rst_n = 1'b1;
        repeat (10) cycle(1'b0, '0, 1'b0);
        check("post_reset_count", underrun_count, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
